// File: rtl/fb_read_arbiter_pkg.sv
// Shared framebuffer read-port constants and the return-path tag layout,
// common to the line fetcher, the framebuffer RAM and the read arbiter.
package fb_read_arbiter_pkg;
   localparam int FB_AW = 14;
   localparam int FB_DW = 20;

   // One bit per requester; travels alongside each read until its data returns.
   typedef struct packed {
      logic a;
      logic b;
   } rd_tag_t;
endpackage

// File: rtl/fb_read_arbiter_rd_tag_pipe.sv
// DEPTH-stage valid/tag shift register with synchronous active-low clear,
// used to tag each RAM read with the port that issued it.
module fb_read_arbiter_rd_tag_pipe
   import fb_read_arbiter_pkg::*;
#(
   parameter int DEPTH = 1,
   parameter int W     = $bits(rd_tag_t)
) (
   input  logic         sys_clk,
   input  logic         rst_n,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout
);
   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_stage
         logic [W-1:0] q_reg;
         if (gi == 0) begin : g_first
            always_ff @(posedge sys_clk) begin
               if (!rst_n) q_reg <= '0;
               else        q_reg <= din;
            end
         end else begin : g_next
            always_ff @(posedge sys_clk) begin
               if (!rst_n) q_reg <= '0;
               else        q_reg <= g_stage[gi-1].q_reg;
            end
         end
      end
   endgenerate

   assign dout = g_stage[DEPTH-1].q_reg;
endmodule

// File: rtl/fb_read_arbiter.sv
// Shares the framebuffer RAM read port between the HUB75 line fetcher (A, high
// priority) and the neopixel/aux reader (B), with aging so B cannot starve.
module fb_read_arbiter
   import fb_read_arbiter_pkg::*;
#(
   parameter int AW       = FB_AW,
   parameter int DW       = FB_DW,
   parameter int RD_LAT   = 1,
   parameter int MAX_WAIT = 16
) (
   input  logic          sys_clk,
   input  logic          rst_n,
   input  logic          a_req,
   input  logic [AW-1:0] a_addr,
   output logic          a_gnt,
   output logic          a_rvalid,
   input  logic          b_req,
   input  logic [AW-1:0] b_addr,
   output logic          b_gnt,
   output logic          b_rvalid,
   output logic [DW-1:0] rdata,
   output logic [AW-1:0] ram_raddr,
   output logic          ram_re,
   input  logic [DW-1:0] ram_rdata,
   output logic          b_forced
);
   localparam int             WCW      = $clog2(MAX_WAIT + 1);
   localparam logic [WCW-1:0] WAIT_MAX = WCW'(MAX_WAIT);

   logic [WCW-1:0] wait_cnt_reg;
   logic [WCW-1:0] wait_cnt_next;
   logic [AW-1:0]  raddr_reg;
   logic           force_b;
   rd_tag_t        tag_in;
   rd_tag_t        tag_out;

   // Grants are suppressed outright while reset is held, whatever the requests.
   always_comb begin
      a_gnt    = 1'b0;
      b_gnt    = 1'b0;
      b_forced = 1'b0;
      force_b  = a_req && b_req && (wait_cnt_reg == WAIT_MAX);
      if (rst_n) begin
         if (force_b) begin
            b_gnt    = 1'b1;
            b_forced = 1'b1;
         end else if (a_req) begin
            a_gnt = 1'b1;
         end else if (b_req) begin
            b_gnt = 1'b1;
         end
      end
   end

   assign ram_re    = a_gnt | b_gnt;
   assign ram_raddr = a_gnt ? a_addr : (b_gnt ? b_addr : raddr_reg);

   always_comb begin
      wait_cnt_next = wait_cnt_reg;
      if (b_gnt || !b_req)
         wait_cnt_next = '0;
      else if (wait_cnt_reg != WAIT_MAX)
         wait_cnt_next = wait_cnt_reg + 1'b1;
   end

   always_ff @(posedge sys_clk) begin
      if (!rst_n) begin
         wait_cnt_reg <= '0;
         raddr_reg    <= '0;
      end else begin
         wait_cnt_reg <= wait_cnt_next;
         if (ram_re) raddr_reg <= ram_raddr;
      end
   end

   assign tag_in = '{a: a_gnt, b: b_gnt};

   fb_read_arbiter_rd_tag_pipe #(
      .DEPTH (RD_LAT),
      .W     ($bits(rd_tag_t))
   ) u_tag_pipe (
      .sys_clk (sys_clk),
      .rst_n   (rst_n),
      .din     (tag_in),
      .dout    (tag_out)
   );

   assign a_rvalid = tag_out.a;
   assign b_rvalid = tag_out.b;
   assign rdata    = ram_rdata;
endmodule

// File: tb/tb_fb_read_arbiter.sv
// Drives three arbiter configurations with one shared stimulus stream and checks
// every cycle against a per-configuration model of grants and read returns.
module tb_fb_read_arbiter;
   localparam int AW = 14;
   localparam int DW = 20;
   localparam int NK = 3;

   function automatic int lat_of(input int k);
      return (k == 0) ? 1 : (k == 1) ? 2 : 3;
   endfunction

   function automatic int mw_of(input int k);
      return (k == 1) ? 1 : 16;
   endfunction

   function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
      return {a ^ 14'h2A5A, a[5:0] ^ 6'h15};
   endfunction

   logic          sys_clk;
   logic          rst_n;
   logic          a_req;
   logic [AW-1:0] a_addr;
   logic          b_req;
   logic [AW-1:0] b_addr;

   logic [NK-1:0] a_gnt_v, b_gnt_v, a_rv_v, b_rv_v, re_v, forced_v;
   logic [AW-1:0] raddr_v [NK];
   logic [DW-1:0] rdata_v [NK];

   int checks = 0;
   int passes = 0;
   int cyc    = 0;

   int            denied    [NK];
   logic [AW-1:0] last_addr [NK];
   bit            ret_a     [NK][1024];
   bit            ret_b     [NK][1024];
   logic [AW-1:0] ret_addr  [NK][1024];

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   genvar gi;
   generate
      for (gi = 0; gi < NK; gi++) begin : g_dut
         localparam int LAT = lat_of(gi);
         localparam int MW  = mw_of(gi);
         logic [DW-1:0] rd_pipe [LAT];

         fb_read_arbiter #(
            .AW(AW), .DW(DW), .RD_LAT(LAT), .MAX_WAIT(MW)
         ) u_dut (
            .sys_clk   (sys_clk),
            .rst_n     (rst_n),
            .a_req     (a_req),
            .a_addr    (a_addr),
            .a_gnt     (a_gnt_v[gi]),
            .a_rvalid  (a_rv_v[gi]),
            .b_req     (b_req),
            .b_addr    (b_addr),
            .b_gnt     (b_gnt_v[gi]),
            .b_rvalid  (b_rv_v[gi]),
            .rdata     (rdata_v[gi]),
            .ram_raddr (raddr_v[gi]),
            .ram_re    (re_v[gi]),
            .ram_rdata (rd_pipe[LAT-1]),
            .b_forced  (forced_v[gi])
         );

         // RAM with LAT cycles of registered read latency
         always @(posedge sys_clk) begin
            rd_pipe[0] <= memf(raddr_v[gi]);
            for (int j = 1; j < LAT; j++) rd_pipe[j] <= rd_pipe[j-1];
         end
      end
   endgenerate

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
   endtask

   task automatic step(input logic ar, input logic [AW-1:0] aa, input logic br,
                       input logic [AW-1:0] ba, input logic rn, input bit chk_on);
      logic          ea, eb, ef;
      logic [AW-1:0] ex_addr;
      int            lat, mw;
      a_req  = ar;
      a_addr = aa;
      b_req  = br;
      b_addr = ba;
      rst_n  = rn;
      @(negedge sys_clk);
      for (int k = 0; k < NK; k++) begin
         lat = lat_of(k);
         mw  = mw_of(k);
         ef  = rn && ar && br && (denied[k] == mw);
         eb  = rn && (ef || (!ar && br));
         ea  = rn && ar && !ef;
         ex_addr = ea ? aa : (eb ? ba : last_addr[k]);
         if (chk_on) begin
            check($sformatf("a_gnt[%0d]", k),    a_gnt_v[k],  ea);
            check($sformatf("b_gnt[%0d]", k),    b_gnt_v[k],  eb);
            check($sformatf("ram_re[%0d]", k),   re_v[k],     ea | eb);
            check($sformatf("b_forced[%0d]", k), forced_v[k], ef);
            check($sformatf("ram_raddr[%0d]", k), raddr_v[k], ex_addr);
            check($sformatf("a_rvalid[%0d]", k), a_rv_v[k],   ret_a[k][cyc]);
            check($sformatf("b_rvalid[%0d]", k), b_rv_v[k],   ret_b[k][cyc]);
            if (ret_a[k][cyc] || ret_b[k][cyc])
               check($sformatf("rdata[%0d]", k), rdata_v[k], memf(ret_addr[k][cyc]));
         end
         if (ea || eb) begin
            ret_a[k][cyc+lat]    = ea;
            ret_b[k][cyc+lat]    = eb;
            ret_addr[k][cyc+lat] = ex_addr;
            last_addr[k]         = ex_addr;
         end
         if (!rn) begin
            for (int j = 1; j <= 3; j++) begin
               ret_a[k][cyc+j] = 1'b0;
               ret_b[k][cyc+j] = 1'b0;
            end
            last_addr[k] = '0;
            denied[k]    = 0;
         end else if (eb || !br) begin
            denied[k] = 0;
         end else if (denied[k] < mw) begin
            denied[k]++;
         end
      end
      $display("cyc %0d rst_n=%0b a_req=%0b a_addr=%h b_req=%0b b_addr=%h a_gnt=%b b_gnt=%b a_rv=%b b_rv=%b forced=%b",
               cyc, rn, ar, aa, br, ba, a_gnt_v, b_gnt_v, a_rv_v, b_rv_v, forced_v);
      cyc++;
      @(posedge sys_clk);
      #1;
   endtask

   initial begin
      logic          ar, br;
      logic [AW-1:0] aa, ba;
      for (int k = 0; k < NK; k++) begin
         denied[k]    = 0;
         last_addr[k] = '0;
      end
      a_req = 0; b_req = 0; a_addr = '0; b_addr = '0; rst_n = 0;

      // reset held with both requests high, then the first active cycle
      step(1, 14'h0011, 1, 14'h0022, 0, 0);
      step(1, 14'h0011, 1, 14'h0022, 0, 1);
      step(1, 14'h0011, 1, 14'h0022, 0, 1);
      step(1, 14'h0005, 1, 14'h0100, 1, 1);

      // A alone, back-to-back sweep
      for (int i = 0; i < 64; i++) step(1, AW'(i), 0, 14'h0000, 1, 1);

      // continuous contention exercises aging on every configuration
      for (int i = 0; i < 40; i++) step(1, AW'($urandom), 1, AW'($urandom), 1, 1);
      step(0, 14'h0000, 0, 14'h0000, 1, 1);

      // B alone, then A takes over the cycle B drops
      step(0, 14'h0000, 1, 14'h3F00, 1, 1);
      step(1, 14'h0123, 0, 14'h3F00, 1, 1);
      for (int i = 0; i < 4; i++) step(0, 14'h0000, 0, 14'h0000, 1, 1);

      // random request patterns
      for (int i = 0; i < 200; i++) begin
         ar = 1'($urandom);
         br = 1'($urandom_range(0, 3) != 0);
         aa = AW'($urandom);
         ba = AW'($urandom);
         step(ar, aa, br, ba, 1, 1);
      end

      // one-cycle reset with reads in flight, then aging restarts from zero
      for (int i = 0; i < 5; i++) step(1, AW'(14'h0200 + i), 1, 14'h3F10, 1, 1);
      step(1, 14'h0300, 1, 14'h3F20, 0, 1);
      for (int i = 0; i < 22; i++) step(1, AW'(14'h0400 + i), 1, 14'h3F30, 1, 1);
      for (int i = 0; i < 5; i++) step(0, 14'h0000, 0, 14'h0000, 1, 1);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule

// File: doc/fb_read_arbiter.md
Name: fb_read_arbiter

Overview:
- Shares the single framebuffer RAM read port between two requesters.
- Port A is the real-time HUB75 line fetcher. Port B is the low-priority neopixel/aux reader, which reads the neopixel region of the same RAM.
- Fixed priority favours A. An aging counter guarantees B forward progress.
- Sits between the RAM read side and its readers. Runs entirely in the system clock domain.

Parameters:
- AW, 14, read address width.
- DW, 20, read data width.
- RD_LAT, 1, RAM read latency in cycles (ram_re to ram_rdata valid); legal range 1..3.
- MAX_WAIT, 16, consecutive cycles B may be denied before it is force-granted; legal range 1..255.

Ports:
- sys_clk  in  1  system clock; all logic is on its rising edge.
- rst_n  in  1  reset: synchronous, active-low.
- a_req  in  1  port A read request, level.
- a_addr  in  AW  port A read address.
- a_gnt  out  1  port A request accepted this cycle.
- a_rvalid  out  1  rdata belongs to port A this cycle.
- b_req  in  1  port B read request, level.
- b_addr  in  AW  port B read address.
- b_gnt  out  1  port B request accepted this cycle.
- b_rvalid  out  1  rdata belongs to port B this cycle.
- rdata  out  DW  returned read data, shared by both ports and qualified by a_rvalid/b_rvalid.
- ram_raddr  out  AW  RAM read address.
- ram_re  out  1  RAM read enable.
- ram_rdata  in  DW  RAM read data.
- b_forced  out  1  one-cycle pulse when B wins through aging (debug).

Behaviour:
- Grant logic is combinational from the request inputs and the aging state. Same-cycle grant.
- ram_re = a_gnt | b_gnt.
- ram_raddr = address of the granted port. When neither port is granted, ram_raddr holds its last value.
- At most one grant per cycle; a_gnt and b_gnt are never both 1.
- Priority:
  - If a_req && b_req && wait_cnt == MAX_WAIT: b_gnt = 1, a_gnt = 0, b_forced = 1.
  - Else if a_req: a_gnt = 1.
  - Else if b_req: b_gnt = 1.
- wait_cnt is a register of width clog2(MAX_WAIT+1).
  - Clears to 0 when b_gnt or !b_req.
  - Increments when b_req && !b_gnt.
  - Saturates at MAX_WAIT.
- A forced B grant stalls A by exactly one cycle. A's requester keeps a_req/a_addr stable until a_gnt.
- Requester contract: a request is consumed only in a cycle with its gnt. The arbiter does not latch the address.
- Return path:
  - A tag shift register RD_LAT deep, 2 bits (A, B), shifts every cycle and is loaded with {a_gnt, b_gnt}.
  - a_rvalid/b_rvalid are the tag outputs, exactly RD_LAT cycles after the corresponding gnt.
  - rdata = ram_rdata passed through combinationally, so data and valid are aligned.
- Back-to-back grants every cycle are supported: full throughput, one read per cycle, no bubbles.
- Reset (rst_n low at a rising edge), including mid-operation:
  - wait_cnt = 0, tag pipe cleared, a_rvalid = b_rvalid = 0, ram_raddr = 0.
  - While rst_n is low: a_gnt = b_gnt = ram_re = b_forced = 0, regardless of requests.
  - In-flight reads at reset are dropped; no rvalid ever appears for them.
- Boundaries:
  - MAX_WAIT = 1 forces B on every second contended cycle.
  - A request deasserting without a grant is legal and leaves no residue.
  - Address wrap is the RAM's concern; addresses pass unmodified.

Decomposition:
- Shared package holds the read port width constants (FB_AW = 14, FB_DW = 20), so the line fetcher, RAM and arbiter agree.
- One natural sub-module: rd_tag_pipe, a parameterised RD_LAT-deep valid/tag shift register with synchronous active-low clear.

Test Plan:
- Reset with both requests held high, then release:
  - During reset: no gnt, no ram_re.
  - First active cycle: a_gnt = 1, ram_raddr = a_addr.
- A only, addresses 0x0000..0x003F back-to-back (RD_LAT = 1):
  - 64 consecutive a_gnt.
  - a_rvalid high for 64 cycles, starting 1 cycle after the first grant.
  - rdata matches a RAM model each cycle.
- A and B requesting continuously, MAX_WAIT = 16:
  - B granted exactly every 17th cycle, with a b_forced pulse each time.
  - A granted the other 16 cycles.
  - wait_cnt returns to 0 after each B grant.
- B alone with addr 0x3F00, then A asserts in the same cycle B drops:
  - b_gnt for B's cycle, a_gnt next cycle.
  - rvalids appear in the same order, RD_LAT later.
- RD_LAT = 3, interleaved A/B grants:
  - Each rvalid appears exactly 3 cycles after its gnt, tagged to the correct port.
- rst_n pulsed low for 1 cycle with 3 reads in flight (RD_LAT = 3):
  - No rvalid for those reads.
  - wait_cnt restarts from 0.
